// File: rtl/servo_sequencer.sv
// Servo position sequencer: walks a table of target pulse widths and dwell times.
// It slews pulse_width toward each target by a bounded step per PWM frame and updates only at frame boundaries.
module servo_sequencer #(
  parameter int WIDTH        = 20,
  parameter int DEPTH        = 8,
  parameter int MIN_PULSE    = 25000,
  parameter int MAX_PULSE    = 125000,
  parameter int CENTER_PULSE = 75000,
  parameter int SLEW         = 2500,
  parameter int DWELL_W      = 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_pos,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW:0]        num_steps,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   pulse_width,
  output logic               busy,
  output logic               at_target,
  output logic [AW-1:0]      step_idx,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SLEW  = 2'd2;
  localparam logic [1:0] ST_DWELL = 2'd3;

  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] CENTER_W = WIDTH'(CENTER_PULSE);
  localparam logic [WIDTH-1:0] SLEW_W   = WIDTH'(SLEW);
  localparam logic [WIDTH:0]   SLEW_MAG = (WIDTH+1)'(SLEW);
  localparam logic [AW:0]      DEPTH_S  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]   tbl_pos   [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  logic [1:0]         state;
  logic [AW:0]        run_steps;
  logic               run_loop;
  logic [WIDTH-1:0]   target;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [1:0]         state_nx;
  logic [AW-1:0]      idx_nx;
  logic [AW:0]        steps_nx;
  logic               loop_nx;
  logic [WIDTH-1:0]   target_nx;
  logic [DWELL_W-1:0] dwell_nx;
  logic [WIDTH-1:0]   pw_nx;
  logic               done_nx;
  logic [AW:0]        steps_in;
  logic               last_step;

  function automatic logic [WIDTH-1:0] clamp_pos(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] r;
    if (p < MIN_W) begin
      r = MIN_W;
    end else if (p > MAX_W) begin
      r = MAX_W;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // One frame of slewing: land on the target when within one step, else move a full step toward it.
  function automatic logic [WIDTH-1:0] slew_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag;
    logic [WIDTH-1:0]      r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= SLEW_MAG) begin
      r = tgt;
    end else if (diff[WIDTH]) begin
      r = cur - SLEW_W;
    end else begin
      r = cur + SLEW_W;
    end
    return r;
  endfunction

  assign steps_in  = (num_steps > DEPTH_S) ? DEPTH_S : num_steps;
  assign last_step = ({1'b0, step_idx} >= (run_steps - (AW+1)'(1)));

  // Next-state and datapath decisions; stop overrides everything else.
  always_comb begin
    state_nx  = state;
    idx_nx    = step_idx;
    steps_nx  = run_steps;
    loop_nx   = run_loop;
    target_nx = target;
    dwell_nx  = dwell_cnt;
    pw_nx     = pulse_width;
    done_nx   = 1'b0;
    if (stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (num_steps != (AW+1)'(0))) begin
            state_nx = ST_LOAD;
            idx_nx   = {AW{1'b0}};
            steps_nx = steps_in;
            loop_nx  = loop;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_LOAD: begin
          target_nx = clamp_pos(tbl_pos[step_idx]);
          dwell_nx  = tbl_dwell[step_idx];
          state_nx  = ST_SLEW;
        end
        ST_SLEW: begin
          if (frame_start) begin
            pw_nx = slew_step(pulse_width, target);
            if (pw_nx == target) begin
              state_nx = ST_DWELL;
            end else begin
              state_nx = ST_SLEW;
            end
          end else begin
            state_nx = ST_SLEW;
          end
        end
        ST_DWELL: begin
          if (frame_start) begin
            if (dwell_cnt == {DWELL_W{1'b0}}) begin
              if (!last_step) begin
                idx_nx   = step_idx + AW'(1);
                state_nx = ST_LOAD;
              end else if (run_loop) begin
                idx_nx   = {AW{1'b0}};
                state_nx = ST_LOAD;
              end else begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
              end
            end else begin
              dwell_nx = dwell_cnt - DWELL_W'(1);
            end
          end else begin
            state_nx = ST_DWELL;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Table storage; writes land in any state and are only read back in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_pos[i]   <= CENTER_W;
        tbl_dwell[i] <= {DWELL_W{1'b0}};
      end
    end else if (wr_en) begin
      tbl_pos[wr_addr]   <= wr_pos;
      tbl_dwell[wr_addr] <= wr_dwell;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      step_idx    <= {AW{1'b0}};
      run_steps   <= {(AW+1){1'b0}};
      run_loop    <= 1'b0;
      target      <= CENTER_W;
      dwell_cnt   <= {DWELL_W{1'b0}};
      pulse_width <= CENTER_W;
      busy        <= 1'b0;
      at_target   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      step_idx    <= idx_nx;
      run_steps   <= steps_nx;
      run_loop    <= loop_nx;
      target      <= target_nx;
      dwell_cnt   <= dwell_nx;
      pulse_width <= pw_nx;
      busy        <= (state_nx != ST_IDLE);
      at_target   <= (state_nx == ST_DWELL);
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer: vector table, directed corner sequences,
// and randomized tables checked against a frame-level trajectory model.
module tb_servo_sequencer;

  localparam int CENTER = 75000;
  localparam int PMIN   = 25000;
  localparam int PMAX   = 125000;
  localparam int STEP   = 2500;
  localparam int DEPTH  = 8;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [19:0] wr_pos;
  logic [7:0]  wr_dwell;
  logic [3:0]  num_steps;
  logic        loop;
  logic        start;
  logic        stop;
  logic [19:0] pulse_width;
  logic        busy;
  logic        at_target;
  logic [2:0]  step_idx;
  logic        done;

  servo_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_pos(wr_pos), .wr_dwell(wr_dwell),
    .num_steps(num_steps), .loop(loop), .start(start), .stop(stop),
    .pulse_width(pulse_width), .busy(busy), .at_target(at_target),
    .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        frame;
    logic [19:0] pw;
    logic        at;
    logic        busy;
    logic        done;
    logic [2:0]  idx;
  } vec_t;

  typedef struct {
    int pw;
    int at;
    int idx;
    int busy;
    int done;
  } exp_t;

  vec_t vec [13];
  exp_t q [$];
  int   tb_pos   [DEPTH];
  int   tb_dwell [DEPTH];
  int   model_pw;
  int   model_idx;
  int   n_checks;
  int   n_fail;
  int   obs_min, obs_max, max_delta;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int p);
    if (p < PMIN) return PMIN;
    if (p > PMAX) return PMAX;
    return p;
  endfunction

  task automatic shadow_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tb_pos[i]   = CENTER;
      tb_dwell[i] = 0;
    end
    model_pw  = CENTER;
    model_idx = 0;
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en    = 1'b1;
    wr_addr  = 3'(a);
    wr_pos   = 20'(p);
    wr_dwell = 8'(d);
    tick();
    wr_en    = 1'b0;
    tb_pos[a]   = p;
    tb_dwell[a] = d;
  endtask

  task automatic do_start(input int n, input logic lp);
    num_steps = 4'(n);
    loop      = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("start_busy", busy, 1);
    check("start_idx", step_idx, 0);
    check("start_at", at_target, 0);
    tick();
  endtask

  // Expected outputs after each consumed frame, from the table rules alone.
  task automatic build_expect(input int n, input logic lp, input int passes);
    int   cnt;
    int   pw;
    int   total;
    exp_t e;
    cnt   = (n > DEPTH) ? DEPTH : n;
    pw    = model_pw;
    total = cnt * passes;
    q.delete();
    for (int s = 0; s < total; s++) begin
      int k;
      int tgt;
      k   = s % cnt;
      tgt = clampi(tb_pos[k]);
      do begin
        if (tgt > pw) pw = (tgt - pw > STEP) ? pw + STEP : tgt;
        else          pw = (pw - tgt > STEP) ? pw - STEP : tgt;
        e = '{pw, (pw == tgt) ? 1 : 0, k, 1, 0};
        q.push_back(e);
      end while (pw != tgt);
      for (int d = 0; d < tb_dwell[k]; d++) begin
        e = '{pw, 1, k, 1, 0};
        q.push_back(e);
      end
      if (s == total - 1 && !lp) begin
        e = '{pw, 0, k, 0, 1};
        model_idx = k;
      end else begin
        e = '{pw, 0, (k + 1) % cnt, 1, 0};
        model_idx = (k + 1) % cnt;
      end
      q.push_back(e);
    end
    model_pw = pw;
  endtask

  task automatic run_expect(input string name);
    int prev;
    int gap;
    prev = model_pw;
    for (int i = 0; i < q.size(); i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check({name, "_pw"}, pulse_width, q[i].pw);
      check({name, "_at"}, at_target, q[i].at);
      check({name, "_busy"}, busy, q[i].busy);
      check({name, "_done"}, done, q[i].done);
      if (q[i].done == 0) check({name, "_idx"}, step_idx, q[i].idx);
      if (int'(pulse_width) > obs_max) obs_max = pulse_width;
      if (int'(pulse_width) < obs_min) obs_min = pulse_width;
      if (i > 0) begin
        if (q[i-1].pw - int'(pulse_width) > max_delta) max_delta = q[i-1].pw - int'(pulse_width);
        if (int'(pulse_width) - q[i-1].pw > max_delta) max_delta = int'(pulse_width) - q[i-1].pw;
      end
      gap = $urandom_range(2, 4);
      tick();
      check({name, "_done_1cyc"}, done, 0);
      repeat (gap - 1) tick();
    end
  endtask

  task automatic frame_chk(input string name, input int pw, input int at, input int idx);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({name, "_pw"}, pulse_width, pw);
    check({name, "_at"}, at_target, at);
    check({name, "_idx"}, step_idx, idx);
    check({name, "_busy"}, busy, 1);
    tick();
    tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_addr = 3'd0;
    wr_pos = 20'd0; wr_dwell = 8'd0; num_steps = 4'd0; loop = 1'b0;
    start = 1'b0; stop = 1'b0;
    n_checks = 0; n_fail = 0;

    //            start frame  pw          at    busy  done  idx
    vec[0]  = '{1'b1, 1'b0, 20'd75000, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[1]  = '{1'b0, 1'b1, 20'd75000, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[2]  = '{1'b0, 1'b1, 20'd77500, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[3]  = '{1'b1, 1'b0, 20'd77500, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[4]  = '{1'b0, 1'b1, 20'd80000, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[5]  = '{1'b0, 1'b1, 20'd82500, 1'b0, 1'b1, 1'b0, 3'd0};
    vec[6]  = '{1'b0, 1'b1, 20'd85000, 1'b1, 1'b1, 1'b0, 3'd0};
    vec[7]  = '{1'b0, 1'b0, 20'd85000, 1'b1, 1'b1, 1'b0, 3'd0};
    vec[8]  = '{1'b0, 1'b1, 20'd85000, 1'b1, 1'b1, 1'b0, 3'd0};
    vec[9]  = '{1'b0, 1'b1, 20'd85000, 1'b1, 1'b1, 1'b0, 3'd0};
    vec[10] = '{1'b0, 1'b1, 20'd85000, 1'b0, 1'b0, 1'b1, 3'd0};
    vec[11] = '{1'b0, 1'b0, 20'd85000, 1'b0, 1'b0, 1'b0, 3'd0};
    vec[12] = '{1'b0, 1'b1, 20'd85000, 1'b0, 1'b0, 1'b0, 3'd0};

    // Reset
    shadow_reset();
    tick(); tick();
    rst = 1'b0;
    check("rst_pw", pulse_width, CENTER);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_at", at_target, 0);
    check("rst_idx", step_idx, 0);
    for (int i = 0; i < 20; i++) begin
      frame_start = i[0];
      tick();
    end
    frame_start = 1'b0;
    check("idle_pw", pulse_width, CENTER);
    check("idle_busy", busy, 0);

    // Single step from the vector table
    wr(0, 85000, 2);
    num_steps = 4'd1;
    loop      = 1'b0;
    for (int i = 0; i < 13; i++) begin
      start       = vec[i].start;
      frame_start = vec[i].frame;
      tick();
      start       = 1'b0;
      frame_start = 1'b0;
      check($sformatf("vec%0d_pw", i), pulse_width, vec[i].pw);
      check($sformatf("vec%0d_at", i), at_target, vec[i].at);
      check($sformatf("vec%0d_busy", i), busy, vec[i].busy);
      check($sformatf("vec%0d_done", i), done, vec[i].done);
      check($sformatf("vec%0d_idx", i), step_idx, vec[i].idx);
    end
    model_pw  = 85000;
    model_idx = 0;

    // Clamp and partial step
    wr(0, 200000, 0);
    wr(1, 0, 0);
    wr(2, 76000, 0);
    do_start(3, 1'b0);
    build_expect(3, 1'b0, 1);
    obs_min = 1 << 30; obs_max = 0; max_delta = 0;
    run_expect("clamp");
    check("clamp_peak", obs_max, PMAX);
    check("clamp_trough", obs_min, PMIN);
    check("clamp_final", pulse_width, 76000);
    check("clamp_step_bound", (max_delta <= STEP) ? 1 : 0, 1);

    // Ignored commands in IDLE
    num_steps = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_zero_busy", busy, 0);
    check("ign_zero_idx", step_idx, model_idx);
    num_steps = 4'd2;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ign_stop_busy", busy, 0);
    tick();
    check("ign_stop_busy2", busy, 0);
    check("ign_stop_idx", step_idx, model_idx);
    check("ign_stop_pw", pulse_width, model_pw);

    // Loop for three passes, then stop mid-slew
    wr(0, 80000, 0);
    wr(1, 70000, 0);
    do_start(2, 1'b1);
    build_expect(2, 1'b1, 3);
    run_expect("loop");
    model_pw = model_pw + STEP;
    frame_chk("loop_slew", model_pw, 0, 0);
    stop        = 1'b1;
    frame_start = 1'b1;
    tick();
    stop        = 1'b0;
    frame_start = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_pw", pulse_width, model_pw);
    check("stop_at", at_target, 0);
    check("stop_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      check("stopped_pw", pulse_width, model_pw);
      check("stopped_done", done, 0);
    end
    model_idx = 0;

    // Live write of the active entry during DWELL, then reset mid-slew
    wr(0, 77500, 2);
    wr(1, 72500, 0);
    do_start(2, 1'b1);
    frame_chk("live1", 75000, 0, 0);
    frame_chk("live2", 77500, 1, 0);
    wr(0, 80000, 2);
    num_steps = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_idx", step_idx, 0);
    check("busy_start_at", at_target, 1);
    frame_chk("live3", 77500, 1, 0);
    frame_chk("live4", 77500, 1, 0);
    frame_chk("live5", 77500, 0, 1);
    frame_chk("live6", 75000, 0, 1);
    frame_chk("live7", 72500, 1, 1);
    frame_chk("live8", 72500, 0, 0);
    frame_chk("live9", 75000, 0, 0);
    frame_chk("live10", 77500, 0, 0);
    rst = 1'b1;
    tick();
    check("midrst_pw", pulse_width, CENTER);
    check("midrst_busy", busy, 0);
    check("midrst_at", at_target, 0);
    check("midrst_done", done, 0);
    check("midrst_idx", step_idx, 0);
    tick();
    rst = 1'b0;
    shadow_reset();

    // Every entry must hold the neutral position with zero dwell after reset
    do_start(8, 1'b0);
    build_expect(8, 1'b0, 1);
    run_expect("readback");

    // Randomized tables against the trajectory model
    for (int it = 0; it < 6; it++) begin
      int n;
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 3) != 0) wr(a, $urandom_range(10000, 140000), $urandom_range(0, 3));
      end
      n = $urandom_range(1, 15);
      do_start(n, 1'b0);
      build_expect(n, 1'b0, 1);
      run_expect($sformatf("rand%0d", it));
      check($sformatf("rand%0d_idle", it), busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
